imm_decode_stage: RTL and testbench

Parametrised, pipelined immediate-decode stage for the decode/ID path of the pipelined RV CPU. It accepts one 32-bit instruction per cycle over a valid/ready handshake and classifies its immediate format. It emits the immediate sign- or zero-extended to XLEN bits, together with a format code, an illegal-opcode flag and a passthrough tag. A 2-entry skid buffer decouples upstream fetch from downstream stalls and keeps in_ready purely registered.

---
 rtl/imm_decode_stage.sv | 174 +++++++++++++++++
 tb/tb_imm_decode_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: RV immediate decoder feeding a 2-entry skid buffer (head + skid).
// Define IMM_ZICSR_EN to decode SYSTEM (1110011) as CSR zimm / CSR-address immediates.
module imm_decode_stage #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_ZICSR_EN
  localparam logic [2:0] FMT_Z    = 3'd6;
`endif

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  typedef struct packed {
    logic [XLEN-1:0]  imm;
    logic [2:0]       fmt;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  occ_e        occ_q, occ_d;
  entry_t      head_q, head_d;
  entry_t      skid_q, skid_d;
  logic        inReady_q;
  logic [31:0] decImm32;
  logic [2:0]  decFmt;
  logic        decIll;
  entry_t      newEntry;
  logic        accept;
  logic        drain;

  // Every format fits in 32 bits with its sign at bit 31 (zimm has bit 31 clear),
  // so a single 32->XLEN sign extension covers both XLEN settings.
  always_comb begin
    decImm32 = '0;
    decFmt   = FMT_NONE;
    decIll   = 1'b0;
    if (in_inst[1:0] != 2'b11) begin
      decIll = 1'b1;
    end else begin
      case (in_inst[6:0])
        7'b0010011, 7'b0000011, 7'b1100111: begin
          decImm32 = {{20{in_inst[31]}}, in_inst[31:20]};
          decFmt   = FMT_I;
        end
        7'b0100011: begin
          decImm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
          decFmt   = FMT_S;
        end
        7'b1100011: begin
          decImm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
          decFmt   = FMT_B;
        end
        7'b1101111: begin
          decImm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};
          decFmt   = FMT_J;
        end
        7'b0110111, 7'b0010111: begin
          decImm32 = {in_inst[31:12], 12'b0};
          decFmt   = FMT_U;
        end
        7'b0110011: begin
          decIll = 1'b0;
        end
`ifdef IMM_ZICSR_EN
        7'b1110011: begin
          if (in_inst[14:12] inside {3'b101, 3'b110, 3'b111}) begin
            decImm32 = {27'b0, in_inst[19:15]};
            decFmt   = FMT_Z;
          end else begin
            decImm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            decFmt   = FMT_I;
          end
        end
`endif
        default: begin
          decIll = 1'b1;
        end
      endcase
    end
  end

  assign newEntry.imm     = XLEN'($signed(decImm32));
  assign newEntry.fmt     = decFmt;
  assign newEntry.illegal = decIll;
  assign newEntry.tag     = in_tag;

  assign accept = in_valid && inReady_q;
  assign drain  = out_valid && out_ready;

  // Head always holds the oldest entry; the skid only fills while the head is stalled.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            head_d = newEntry;
            occ_d  = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (accept && drain) begin
            head_d = newEntry;
          end else if (accept) begin
            skid_d = newEntry;
            occ_d  = OCC_TWO;
          end else if (drain) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (drain) begin
            head_d = skid_q;
            occ_d  = OCC_ONE;
          end
        end
        default: begin
          occ_d = OCC_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q     <= OCC_EMPTY;
      head_q    <= '0;
      skid_q    <= '0;
      inReady_q <= 1'b1;
    end else begin
      occ_q     <= occ_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      inReady_q <= (occ_d != OCC_TWO);
    end
  end

  assign in_ready    = inReady_q;
  assign out_valid   = (occ_q != OCC_EMPTY);
  assign out_imm     = head_q.imm;
  assign out_fmt     = head_q.fmt;
  assign out_illegal = head_q.illegal;
  assign out_tag     = head_q.tag;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: XLEN=32 and XLEN=64 instances share stimulus,
// checked against a queue-based reference model plus a table of known decodes.
module tb_imm_decode_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_inst;
  logic [31:0] in_tag;

  logic        inReady32, outValid32, outIll32;
  logic [31:0] outImm32, outTag32;
  logic [2:0]  outFmt32;
  logic        inReady64, outValid64, outIll64;
  logic [63:0] outImm64;
  logic [31:0] outTag64;
  logic [2:0]  outFmt64;

  always #5 clk = ~clk;

  imm_decode_stage #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(inReady32), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(outValid32), .out_ready(out_ready), .out_imm(outImm32),
    .out_fmt(outFmt32), .out_illegal(outIll32), .out_tag(outTag32)
  );

  imm_decode_stage #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(inReady64), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(outValid64), .out_ready(out_ready), .out_imm(outImm64),
    .out_fmt(outFmt64), .out_illegal(outIll64), .out_tag(outTag64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tag;
  } entry_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        ill;
  } vec_t;

  entry_t sb[$];
  vec_t   vecs[13];
  int     checks = 0;
  int     errors = 0;
  int     drainCount = 0;
  logic [31:0] tagCtr = 32'h1000;

  // Reference decode: build each immediate as a signed value of its natural width and widen.
  function automatic entry_t refDecode(input logic [31:0] inst, input logic [31:0] tag);
    entry_t e;
    logic signed [11:0] i12;
    logic signed [12:0] b13;
    logic signed [20:0] j21;
    logic signed [31:0] u32;
    e.imm = '0;
    e.fmt = 3'd0;
    e.ill = 1'b0;
    e.tag = tag;
    if (inst[1:0] != 2'b11) begin
      e.ill = 1'b1;
    end else begin
      case (inst[6:0])
        7'h13, 7'h03, 7'h67: begin i12 = inst[31:20]; e.imm = longint'(i12); e.fmt = 3'd1; end
        7'h23: begin i12 = {inst[31:25], inst[11:7]}; e.imm = longint'(i12); e.fmt = 3'd2; end
        7'h63: begin b13 = {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}; e.imm = longint'(b13); e.fmt = 3'd3; end
        7'h6F: begin j21 = {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}; e.imm = longint'(j21); e.fmt = 3'd5; end
        7'h37, 7'h17: begin u32 = {inst[31:12], 12'b0}; e.imm = longint'(u32); e.fmt = 3'd4; end
        7'h33: e.fmt = 3'd0;
`ifdef IMM_ZICSR_EN
        7'h73: begin
          if (inst[14:12] >= 3'd5) begin e.imm = 64'(inst[19:15]); e.fmt = 3'd6; end
          else begin i12 = inst[31:20]; e.imm = longint'(i12); e.fmt = 3'd1; end
        end
`endif
        default: e.ill = 1'b1;
      endcase
    end
    return e;
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against the model's view of the buffer.
  task automatic checkOutput(input string name);
    checkValue({name, ".valid32"}, 64'(outValid32), 64'(sb.size() > 0));
    checkValue({name, ".ready32"}, 64'(inReady32), 64'(sb.size() < 2));
    checkValue({name, ".valid64"}, 64'(outValid64), 64'(sb.size() > 0));
    checkValue({name, ".ready64"}, 64'(inReady64), 64'(sb.size() < 2));
    if (sb.size() > 0) begin
      checkValue({name, ".imm32"}, 64'(outImm32), 64'(sb[0].imm[31:0]));
      checkValue({name, ".imm64"}, outImm64, sb[0].imm);
      checkValue({name, ".fmt32"}, 64'(outFmt32), 64'(sb[0].fmt));
      checkValue({name, ".fmt64"}, 64'(outFmt64), 64'(sb[0].fmt));
      checkValue({name, ".ill32"}, 64'(outIll32), 64'(sb[0].ill));
      checkValue({name, ".tag32"}, 64'(outTag32), 64'(sb[0].tag));
      checkValue({name, ".tag64"}, 64'(outTag64), 64'(sb[0].tag));
    end
  endtask

  // One clock: drive inputs, advance the model across the edge, check 1 time unit later.
  task automatic applyStimulus(input string name, input logic v, input logic [31:0] inst,
                               input logic ordy, input logic fl, output logic accepted);
    logic expDrain;
    entry_t e;
    in_valid  = v;
    in_inst   = inst;
    in_tag    = tagCtr;
    out_ready = ordy;
    flush     = fl;
    e         = refDecode(inst, tagCtr);
    accepted  = v && (sb.size() < 2) && !fl;
    expDrain  = (sb.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      sb.delete();
    end else begin
      if (expDrain) begin
        void'(sb.pop_front());
        drainCount++;
      end
      if (accepted) sb.push_back(e);
    end
    if (accepted) tagCtr++;
    #1;
    checkOutput(name);
  endtask

  task automatic checkHead(input string name, input int idx);
    checkValue({name, ".tbl_imm32"}, 64'(outImm32), 64'(vecs[idx].imm[31:0]));
    checkValue({name, ".tbl_imm64"}, outImm64, vecs[idx].imm);
    checkValue({name, ".tbl_fmt"}, 64'(outFmt32), 64'(vecs[idx].fmt));
    checkValue({name, ".tbl_ill"}, 64'(outIll32), 64'(vecs[idx].ill));
  endtask

  initial begin
    logic acc;
    logic [31:0] rnd;
    logic [31:0] inst;
    logic [6:0] ops[10];
    int idx;
    int startDrains;

    vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
    vecs[1]  = '{32'hFE112E23, 64'hFFFF_FFFF_FFFF_FFFC, 3'd2, 1'b0};
    vecs[2]  = '{32'h123452B7, 64'h0000_0000_1234_5000, 3'd4, 1'b0};
    vecs[3]  = '{32'hFF9FF06F, 64'hFFFF_FFFF_FFFF_FFF8, 3'd5, 1'b0};
    vecs[4]  = '{32'hFE000EE3, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0};
    vecs[5]  = '{32'h0000007F, 64'h0, 3'd0, 1'b1};
    vecs[6]  = '{32'h00000090, 64'h0, 3'd0, 1'b1};
    vecs[7]  = '{32'h00A00033, 64'h0, 3'd0, 1'b0};
    vecs[8]  = '{32'h80000017, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0};
    vecs[9]  = '{32'h7FF00003, 64'h0000_0000_0000_07FF, 3'd1, 1'b0};
    vecs[10] = '{32'h00008067, 64'h0, 3'd1, 1'b0};
`ifdef IMM_ZICSR_EN
    vecs[11] = '{32'h3402D073, 64'h5, 3'd6, 1'b0};
    vecs[12] = '{32'h34011073, 64'h0000_0000_0000_0340, 3'd1, 1'b0};
`else
    vecs[11] = '{32'h3402D073, 64'h0, 3'd0, 1'b1};
    vecs[12] = '{32'h34011073, 64'h0, 3'd0, 1'b1};
`endif
    ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h73};

    reset_n = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_tag = '0;
    #1 reset_n = 1'b0;
    #2;
    checkValue("rst.valid", 64'(outValid32), 64'd0);
    checkValue("rst.ready", 64'(inReady32), 64'd1);
    checkValue("rst.imm64", outImm64, 64'd0);
    checkValue("rst.fmt", 64'(outFmt32), 64'd0);
    checkValue("rst.ill", 64'(outIll32), 64'd0);
    checkValue("rst.tag", 64'(outTag32), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Single beats with an idle drain cycle between them.
    for (int i = 0; i < 13; i++) begin
      applyStimulus("table", 1'b1, vecs[i].inst, 1'b1, 1'b0, acc);
      checkHead($sformatf("table%0d", i), i);
      applyStimulus("table_drain", 1'b0, 32'h0, 1'b1, 1'b0, acc);
    end

    // Back-to-back sw/lui/jal at full throughput.
    for (int i = 1; i <= 3; i++) begin
      applyStimulus("b2b", 1'b1, vecs[i].inst, 1'b1, 1'b0, acc);
      checkHead($sformatf("b2b%0d", i), i);
    end
    applyStimulus("b2b_drain", 1'b0, 32'h0, 1'b1, 1'b0, acc);

    // Backpressure: out_ready low for 3 cycles while 4 beats are offered.
    idx = 0;
    startDrains = drainCount;
    for (int cyc = 0; cyc < 20 && (idx < 4 || sb.size() > 0); cyc++) begin
      applyStimulus("bp", idx < 4, vecs[1 + (idx % 4)].inst, cyc >= 3, 1'b0, acc);
      if (acc) idx++;
      if (cyc == 1) checkValue("bp.ready_low", 64'(inReady32), 64'd0);
      if (cyc >= 1 && cyc <= 2) checkHead("bp.hold", 1);
    end
    checkValue("bp.drained", 64'(drainCount - startDrains), 64'd4);

    // Flush at occupancy 2 with a simultaneous input beat.
    applyStimulus("fl_fill", 1'b1, vecs[2].inst, 1'b0, 1'b0, acc);
    applyStimulus("fl_fill", 1'b1, vecs[3].inst, 1'b0, 1'b0, acc);
    applyStimulus("fl", 1'b1, vecs[4].inst, 1'b0, 1'b1, acc);
    checkValue("flush.valid", 64'(outValid32), 64'd0);
    checkValue("flush.ready", 64'(inReady32), 64'd1);

    // Asynchronous reset mid-stream.
    applyStimulus("rs_fill", 1'b1, vecs[0].inst, 1'b0, 1'b0, acc);
    applyStimulus("rs_fill", 1'b1, vecs[3].inst, 1'b0, 1'b0, acc);
    reset_n = 1'b0;
    #1;
    checkValue("async_rst.valid", 64'(outValid64), 64'd0);
    checkValue("async_rst.ready", 64'(inReady64), 64'd1);
    checkValue("async_rst.imm", outImm64, 64'd0);
    checkValue("async_rst.fmt", 64'(outFmt64), 64'd0);
    checkValue("async_rst.tag", 64'(outTag64), 64'd0);
    sb.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Randomised traffic against the reference model.
    for (int cyc = 0; cyc < 400; cyc++) begin
      rnd = $urandom;
      if ($urandom_range(0, 4) != 0) begin
        inst = {rnd[31:7], ops[$urandom_range(0, 9)]};
      end else begin
        inst = rnd;
      end
      applyStimulus("rand", $urandom_range(0, 3) != 0, inst,
                    $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0, acc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
